intt: RTL and testbench

Inverse number-theoretic transform engine for Kyber-768: takes a 256-coefficient NTT-domain polynomial f_hat and returns the normal-domain polynomial f = NTT⁻¹(f_hat) mod Q. It is the return path paired with the forward `ntt` core and uses the same start/done array-port handshake, so both can be chained or cross-checked at top level. All butterflies run on one shared Cooley-Tukey/Gentleman-Sande datapath over an internal coefficient register file, followed by a final scaling pass.

---
 rtl/intt.sv | 139 +++++++++++++
 tb/tb_intt.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intt.sv
// Kyber-768 inverse NTT: canonical load, 896 shared-datapath butterflies, then a
// 256-cycle scaling pass by 128^-1 mod Q. Result is held on f while done is high.
module intt (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] f_hat [256],
  output logic signed [15:0] f [256],
  output logic               done
);

  localparam int unsigned N       = 256;
  localparam int unsigned Q       = 3329;
  localparam int unsigned QW      = 12;
  localparam int unsigned SCALE_K = 3303;

  typedef enum logic [2:0] {IDLE, LOAD, BFLY, SCALE, DONE} state_t;

  // zeta[i] = 17^bitrev7(i) mod Q, folded at elaboration
  function automatic logic [QW-1:0] zeta_of(input int i);
    int r;
    int z;
    r = 0;
    for (int n = 0; n < 7; n++)
      if (((i >> n) & 1) != 0) r = r | (1 << (6 - n));
    z = 1;
    for (int n = 0; n < r; n++) z = (z * 17) % 3329;
    return QW'(z);
  endfunction

  function automatic logic [QW-1:0] canon(input logic signed [15:0] x);
    logic signed [15:0] r;
    r = x % 16'sd3329;
    if (r < 0) r = r + 16'sd3329;
    return QW'(r);
  endfunction

  logic [QW-1:0] zeta_rom [128];

  for (genvar g = 0; g < 128; g++) begin : g_zeta
    localparam logic [QW-1:0] ZV = zeta_of(g);
    assign zeta_rom[g] = ZV;
  end

  state_t        state;
  logic [QW-1:0] w [N];
  logic [2:0]    layer;
  logic [6:0]    b;
  logic [6:0]    k;
  logic [8:0]    sidx;

  logic [7:0]    len;
  logic [6:0]    mask;
  logic [7:0]    j_a;
  logic [7:0]    j_b;
  logic          grp_end;
  logic [QW-1:0] va;
  logic [QW-1:0] vb;
  logic [12:0]   sum;
  logic [QW-1:0] bf_sum;
  logic [QW-1:0] bf_diff;
  logic [23:0]   prod;
  logic [QW-1:0] bf_prod;
  logic [23:0]   sc_prod;
  logic [QW-1:0] sc_val;

  // Butterfly addressing: len is a power of two, so j = {group bits, 0, offset bits}
  always_comb begin
    len     = 8'(9'd2 << layer);
    mask    = 7'(len - 8'd1);
    j_a     = {b & ~mask, 1'b0} | {1'b0, b & mask};
    j_b     = j_a | len;
    grp_end = (b & mask) == mask;
    va      = w[j_a];
    vb      = w[j_b];
    sum     = 13'(va) + 13'(vb);
    bf_sum  = (sum >= 13'(Q)) ? QW'(sum - 13'(Q)) : QW'(sum);
    bf_diff = (vb >= va) ? (vb - va) : QW'(13'(vb) + 13'(Q) - 13'(va));
    prod    = 24'(zeta_rom[k]) * 24'(bf_diff);
    bf_prod = QW'(prod % 24'(Q));
    sc_prod = 24'(w[sidx[7:0]]) * 24'(SCALE_K);
    sc_val  = QW'(sc_prod % 24'(Q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      layer <= '0;
      b     <= '0;
      k     <= 7'd127;
      sidx  <= '0;
      for (int i = 0; i < N; i++) begin
        w[i] <= '0;
        f[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD;
            done  <= 1'b0;
          end
        end
        LOAD: begin
          for (int i = 0; i < N; i++) w[i] <= canon(f_hat[i]);
          layer <= '0;
          b     <= '0;
          k     <= 7'd127;
          sidx  <= '0;
          state <= BFLY;
        end
        BFLY: begin
          w[j_a] <= bf_sum;
          w[j_b] <= bf_prod;
          if (grp_end) k <= k - 7'd1;
          b <= b + 7'd1;
          if (b == 7'd127) begin
            if (layer == 3'd6) state <= SCALE;
            else               layer <= layer + 3'd1;
          end
        end
        SCALE: begin
          // sidx 0..255 scales; the 257th step publishes the result
          if (sidx[8]) begin
            for (int i = 0; i < N; i++) f[i] <= {4'b0, w[i]};
            done  <= 1'b1;
            state <= DONE;
          end else begin
            w[sidx[7:0]] <= sc_val;
            sidx         <= sidx + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intt.sv
// Self-checking bench for intt: vector table plus multi-cycle corner sequences,
// expectations from a loop-level Kyber NTT/INTT model.
module tb_intt;

  localparam int Q  = 3329;
  localparam int NV = 6;
  localparam int LAT = 1154;

  typedef struct packed {
    logic [255:0][15:0] fh;
    logic [255:0][11:0] ex;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] f_hat [256];
  logic signed [15:0] f [256];
  logic               done;

  int   total = 0;
  int   bad = 0;
  int   zeta [128];
  vec_t vecs [NV];
  vec_t cur;
  vec_t zero_v;

  intt dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .f_hat(f_hat),
    .f    (f),
    .done (done)
  );

  always #5 clk = ~clk;

  function automatic int powmod(input int base, input int e);
    int r;
    int bb;
    int ee;
    r = 1; bb = base % Q; ee = e;
    while (ee > 0) begin
      if ((ee & 1) != 0) r = (r * bb) % Q;
      bb = (bb * bb) % Q;
      ee = ee >> 1;
    end
    return r;
  endfunction

  function automatic int bitrev7(input int x);
    int r;
    r = 0;
    for (int n = 0; n < 7; n++) r = (r << 1) | ((x >> n) & 1);
    return r;
  endfunction

  task automatic model_intt(input int x [256], output int r [256]);
    int a [256];
    int kk;
    int t;
    for (int i = 0; i < 256; i++) a[i] = ((x[i] % Q) + Q) % Q;
    kk = 127;
    for (int ln = 2; ln <= 128; ln = ln * 2)
      for (int st = 0; st < 256; st = st + 2 * ln) begin
        for (int j = st; j < st + ln; j++) begin
          t = a[j];
          a[j] = (t + a[j + ln]) % Q;
          a[j + ln] = (zeta[kk] * ((a[j + ln] - t + Q) % Q)) % Q;
        end
        kk--;
      end
    for (int i = 0; i < 256; i++) r[i] = (a[i] * 3303) % Q;
  endtask

  task automatic model_ntt(input int x [256], output int r [256]);
    int kk;
    int t;
    for (int i = 0; i < 256; i++) r[i] = ((x[i] % Q) + Q) % Q;
    kk = 1;
    for (int ln = 128; ln >= 2; ln = ln / 2)
      for (int st = 0; st < 256; st = st + 2 * ln) begin
        for (int j = st; j < st + ln; j++) begin
          t = (zeta[kk] * r[j + ln]) % Q;
          r[j + ln] = (r[j] - t + Q) % Q;
          r[j] = (r[j] + t) % Q;
        end
        kk++;
      end
  endtask

  task automatic fill_expect(inout vec_t v);
    int x [256];
    int r [256];
    for (int i = 0; i < 256; i++) x[i] = int'($signed(v.fh[i]));
    model_intt(x, r);
    for (int i = 0; i < 256; i++) v.ex[i] = 12'(r[i]);
  endtask

  task automatic apply(input vec_t v);
    for (int i = 0; i < 256; i++) f_hat[i] = v.fh[i];
  endtask

  task automatic check_bit(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", nm, got, exp);
    end
  endtask

  task automatic check_f(input string nm, input logic [255:0][11:0] ex);
    int bi;
    bi = -1;
    for (int i = 0; i < 256; i++)
      if (bi < 0 && f[i] !== {4'b0, ex[i]}) bi = i;
    total++;
    if (bi >= 0) begin
      bad++;
      $display("FAIL %s: f[%0d]=%0d expected %0d", nm, bi, f[bi], ex[bi]);
    end
  endtask

  // Start pulse at edge E; optional extra start at E+extra_at; done must rise at E+LAT exactly
  task automatic run_one(input string nm, input int extra_at);
    int bad_c;
    bad_c = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= LAT; c++) begin
      start = (c == extra_at);
      @(posedge clk);
      #1;
      if (bad_c < 0 && done !== (c == LAT)) bad_c = c;
    end
    start = 1'b0;
    total++;
    if (bad_c >= 0) begin
      bad++;
      $display("FAIL %s_timing: done=%0b at E+%0d expected %0b", nm, done, bad_c, bad_c == LAT);
    end
  endtask

  initial begin
    int src [256];
    int nt [256];

    for (int i = 0; i < 128; i++) zeta[i] = powmod(17, bitrev7(i));
    zero_v = '0;

    // vector table
    vecs[0] = '0;
    for (int i = 0; i < 256; i++) begin
      vecs[1].fh[i] = 16'hFFFF;
      vecs[2].fh[i] = 16'd3328;
      vecs[4].fh[i] = 16'($urandom);
      vecs[5].fh[i] = 16'($urandom);
      src[i] = 0;
    end
    vecs[5].fh[0] = 16'h8000;
    vecs[5].fh[1] = 16'h7FFF;
    src[1] = 1; src[3] = Q - 1; src[255] = Q - 1; src[100] = 1;
    model_ntt(src, nt);
    for (int i = 0; i < 256; i++) begin
      vecs[3].fh[i] = 16'(nt[i]);
      vecs[3].ex[i] = 12'(src[i]);
    end
    for (int v = 0; v < NV; v++) if (v != 3) fill_expect(vecs[v]);

    for (int i = 0; i < 256; i++) f_hat[i] = '0;
    #2 rst_n = 1'b0;
    #1;
    check_bit("reset_done", done, 1'b0);
    check_f("reset_f", zero_v.ex);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      apply(vecs[v]);
      run_one($sformatf("vec%0d", v), 0);
      check_f($sformatf("vec%0d", v), vecs[v].ex);
    end

    // done and f hold after completion
    for (int i = 0; i < 256; i++) f_hat[i] = 16'd7;
    repeat (5) @(posedge clk);
    #1;
    check_bit("hold_done", done, 1'b1);
    check_f("hold_f", vecs[NV-1].ex);

    // back-to-back from DONE with start held through LOAD
    apply(vecs[1]);
    run_one("b2b", 1);
    check_f("b2b", vecs[1].ex);

    // second start while busy is ignored
    apply(vecs[4]);
    run_one("busy", 300);
    check_f("busy", vecs[4].ex);

    // reset in the middle of BFLY
    apply(vecs[3]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_bit("midrst_done", done, 1'b0);
    check_f("midrst_f", zero_v.ex);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_bit("midrst_idle", done, 1'b0);
    run_one("after_rst", 0);
    check_f("after_rst", vecs[3].ex);

    // chained with a forward NTT: random polynomials must come back unchanged
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 256; i++) src[i] = int'($urandom_range(Q - 1, 0));
      model_ntt(src, nt);
      for (int i = 0; i < 256; i++) begin
        cur.fh[i] = ((i % 2) == 1) ? 16'(nt[i] - Q) : 16'(nt[i]);
        cur.ex[i] = 12'(src[i]);
      end
      apply(cur);
      run_one($sformatf("chain%0d", n), 0);
      check_f($sformatf("chain%0d", n), cur.ex);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
